// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_arb_pkg
//  Brief    : Shared types, default constants and a reference round-robin
//             pick function for the UART transmit arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

    // Arbiter FSM: IDLE scans for a winner, LOCK holds the grant for a burst.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam int C_NUM_REQ_DEF   = 2;
    localparam int C_DATA_W_DEF    = 8;
    localparam int C_MAX_BURST_DEF = 16;
    localparam int C_MAX_REQ       = 8;

    // Behavioural round-robin pick: first set bit of valid[n-1:0], scanning
    // upward from ptr+1 and wrapping. Returns a one-hot vector (zero if none).
    function automatic logic [C_MAX_REQ-1:0] rr_pick(
        input logic [C_MAX_REQ-1:0] valid,
        input logic [2:0]           ptr,
        input int                   n
    );
        logic [C_MAX_REQ-1:0] pick;
        int                   idx;
        pick = '0;
        for (int k = 1; k <= C_MAX_REQ; k++) begin
            idx = (int'(ptr) + k) % n;
            if ((k <= n) && (pick == '0) && valid[idx[2:0]]) begin
                pick[idx[2:0]] = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module   : rr_picker
//  Brief    : Combinational round-robin picker. Rotates the request vector so
//             that index ptr+1 lands at bit 0, isolates the lowest set bit,
//             then rotates the one-hot result back to requester numbering.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int N  = 2,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          any
);

    logic [PW-1:0] w_start;
    logic [N-1:0]  w_rot;
    logic [N-1:0]  w_rot_pick;

    // Scan origin is one past the last winner, wrapping at N-1.
    always_comb begin
        if (ptr == PW'(N - 1)) begin
            w_start = '0;
        end else begin
            w_start = ptr + PW'(1);
        end
    end

    // Rotate requests so the scan origin becomes bit 0.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j == ((i + int'(w_start)) % N)) begin
                    w_rot[i] = valid[j];
                end
            end
        end
    end

    // Lowest set bit of the rotated vector is the winner.
    assign w_rot_pick = w_rot & (~w_rot + N'(1));

    // Rotate the one-hot winner back into requester numbering.
    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j == ((i + int'(w_start)) % N)) begin
                    grant[j] = w_rot_pick[i];
                end
            end
        end
    end

    assign any = |valid;

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Brief    : Round-robin, burst-locked arbiter sharing one UART transmitter
//             among several byte-stream requesters. A grant is held until a
//             byte marked last or MAX_BURST bytes have been accepted. Output
//             is a one-entry registered buffer with valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ   = C_NUM_REQ_DEF,
    parameter int DATA_W    = C_DATA_W_DEF,
    parameter int MAX_BURST = C_MAX_BURST_DEF
) (
    input  logic                      clk,
    input  logic                      reset_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]        req_last_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      tx_valid_o,
    output logic [DATA_W-1:0]         tx_data_o,
    input  logic                      tx_ready_i,
    output logic                      busy_o
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [NUM_REQ-1:0]  r_grant;
    logic [PW-1:0]       r_grant_idx;
    logic [PW-1:0]       r_rr_ptr;
    logic [CW-1:0]       r_beat_cnt;
    logic                r_tx_valid;
    logic [DATA_W-1:0]   r_tx_data;

    logic [NUM_REQ-1:0]  w_pick;
    logic                w_any;
    logic [PW-1:0]       w_pick_idx;
    logic [DATA_W-1:0]   w_sel_data;
    logic                w_sel_last;
    logic                w_buf_free;
    logic                w_accept;
    logic                w_burst_end;

    rr_picker #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_picker (
        .valid (req_valid_i),
        .ptr   (r_rr_ptr),
        .grant (w_pick),
        .any   (w_any)
    );

    // Binary index of the picked requester, remembered for the next rr_ptr.
    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick[i]) begin
                w_pick_idx = PW'(i);
            end
        end
    end

    // Route the granted requester's byte and last flag toward the buffer.
    always_comb begin
        w_sel_data = '0;
        w_sel_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                w_sel_data = req_data_i[i*DATA_W +: DATA_W];
                w_sel_last = req_last_i[i];
            end
        end
    end

    // Buffer can take a byte when empty or being drained this cycle; ready
    // never depends on req_valid_i and is zero for non-owners.
    assign w_buf_free  = !r_tx_valid | tx_ready_i;
    assign req_ready_o = r_grant & {NUM_REQ{w_buf_free}};
    assign w_accept    = |(req_valid_i & req_ready_o);
    assign w_burst_end = w_accept &
                         (w_sel_last | (r_beat_cnt == CW'(MAX_BURST - 1)));

    // FSM state register.
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: lock on any request, release at burst end.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = LOCK;
                end
            end
            LOCK: begin
                if (w_burst_end) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Grant ownership, burst beat counter and round-robin pointer.
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_rr_ptr    <= PW'(NUM_REQ - 1);
            r_beat_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant     <= w_pick;
                        r_grant_idx <= w_pick_idx;
                        r_beat_cnt  <= '0;
                    end
                end
                LOCK: begin
                    if (w_burst_end) begin
                        r_grant    <= '0;
                        r_rr_ptr   <= r_grant_idx;
                        r_beat_cnt <= '0;
                    end else if (w_accept) begin
                        r_beat_cnt <= r_beat_cnt + CW'(1);
                    end
                end
                default: begin
                    r_grant <= '0;
                end
            endcase
        end
    end

    // One-entry output buffer: refill on accept, otherwise drain on take.
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
        end else if (w_accept) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_sel_data;
        end else if (tx_ready_i) begin
            r_tx_valid <= 1'b0;
        end
    end

    assign grant_o    = r_grant;
    assign tx_valid_o = r_tx_valid;
    assign tx_data_o  = r_tx_data;
    assign busy_o     = (r_state == LOCK) | r_tx_valid;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_arbiter
//  Brief    : Directed self-checking bench for uart_tx_arbiter (2 requesters,
//             8-bit bytes, MAX_BURST = 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NUM_REQ   = 2;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;

    logic        clk;
    logic        reset_i;
    logic [1:0]  req_valid_i;
    logic [15:0] req_data_i;
    logic [1:0]  req_last_i;
    logic [1:0]  req_ready_o;
    logic [1:0]  grant_o;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-requester pending bytes: bit 8 is last, bits 7:0 the byte.
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [7:0] outq[$];
    logic [1:0] ownq[$];
    logic [7:0] exp_bytes[$];
    logic [1:0] exp_own[$];
    logic [1:0] prev_grant;
    logic [1:0] rr_g[6];

    uart_tx_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk         (clk),
        .reset_i     (reset_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .grant_o     (grant_o),
        .tx_valid_o  (tx_valid_o),
        .tx_data_o   (tx_data_o),
        .tx_ready_i  (tx_ready_i),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: present queue heads, log serializer takes, pop accepted bytes.
    task automatic run_cycle(input logic rdy);
        logic [1:0] fire;
        tx_ready_i     = rdy;
        req_valid_i[0] = (q0.size() != 0);
        req_valid_i[1] = (q1.size() != 0);
        req_data_i     = {(q1.size() != 0) ? q1[0][7:0] : 8'h00,
                          (q0.size() != 0) ? q0[0][7:0] : 8'h00};
        req_last_i     = {(q1.size() != 0) ? q1[0][8] : 1'b0,
                          (q0.size() != 0) ? q0[0][8] : 1'b0};
        #1;
        fire = req_valid_i & req_ready_o;
        if (tx_valid_o && tx_ready_i) outq.push_back(tx_data_o);
        @(posedge clk);
        #1;
        if (fire[0]) void'(q0.pop_front());
        if (fire[1]) void'(q1.pop_front());
        if ((grant_o != 2'b00) && (grant_o != prev_grant)) ownq.push_back(grant_o);
        prev_grant = grant_o;
    endtask

    task automatic drain(input string tag);
        int i;
        i = 0;
        while ((q0.size() != 0 || q1.size() != 0 || tx_valid_o) && i < 60) begin
            run_cycle(1'b1);
            i++;
        end
        check_eq({tag, "_drain"}, {31'd0, (q0.size() == 0 && q1.size() == 0 && !tx_valid_o)}, 32'd1);
    endtask

    task automatic compare_out(input string tag);
        logic [31:0] got;
        check_eq({tag, "_count"}, outq.size(), exp_bytes.size());
        for (int k = 0; k < exp_bytes.size(); k++) begin
            got = (k < outq.size()) ? {24'd0, outq[k]} : 32'hFFFF_FFFF;
            check_eq($sformatf("%s_byte%0d", tag, k), got, {24'd0, exp_bytes[k]});
        end
        if (exp_own.size() != 0) begin
            check_eq({tag, "_owners"}, ownq.size(), exp_own.size());
            for (int k = 0; k < exp_own.size(); k++) begin
                got = (k < ownq.size()) ? {30'd0, ownq[k]} : 32'hFFFF_FFFF;
                check_eq($sformatf("%s_own%0d", tag, k), got, {30'd0, exp_own[k]});
            end
        end
        outq.delete();
        ownq.delete();
        exp_bytes.delete();
        exp_own.delete();
    endtask

    initial begin
        reset_i     = 1'b1;
        req_valid_i = 2'b11;
        req_data_i  = '0;
        req_last_i  = '0;
        tx_ready_i  = 1'b1;
        prev_grant  = 2'b00;
        #2 reset_i  = 1'b0;

        // Reset held with every requester valid: all outputs quiet.
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_grant", grant_o, 2'b00);
        check_eq("rst_ready", req_ready_o, 2'b00);
        check_eq("rst_txv", tx_valid_o, 1'b0);
        check_eq("rst_txd", tx_data_o, 8'h00);
        check_eq("rst_busy", busy_o, 1'b0);
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_first_grant", grant_o, 2'b01);
        check_eq("rst_first_ready", req_ready_o, 2'b01);
        req_valid_i = 2'b00;
        reset_i = 1'b0;
        #1 reset_i = 1'b1;
        check_eq("rst_pulse_grant", grant_o, 2'b00);

        // Single two-byte message from requester 0.
        q0.push_back({1'b0, 8'h48});
        q0.push_back({1'b1, 8'h69});
        run_cycle(1'b1);
        check_eq("msg_grant", grant_o, 2'b01);
        run_cycle(1'b1);
        check_eq("msg_txv0", tx_valid_o, 1'b1);
        check_eq("msg_txd0", tx_data_o, 8'h48);
        run_cycle(1'b1);
        check_eq("msg_txd1", tx_data_o, 8'h69);
        check_eq("msg_release", grant_o, 2'b00);
        check_eq("msg_busy_pending", busy_o, 1'b1);
        run_cycle(1'b1);
        check_eq("msg_txv_empty", tx_valid_o, 1'b0);
        check_eq("msg_busy_idle", busy_o, 1'b0);
        exp_bytes = '{8'h48, 8'h69};
        compare_out("msg");

        // Round robin with continuous one-byte messages; last owner was req0.
        rr_g = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        for (int i = 0; i < 3; i++) begin
            q0.push_back({1'b1, 8'hA0 + 8'(i)});
            q1.push_back({1'b1, 8'hB0 + 8'(i)});
        end
        for (int i = 0; i < 6; i++) begin
            run_cycle(1'b1);
            check_eq($sformatf("rr_grant%0d", i), grant_o, rr_g[i]);
        end
        drain("rr");
        exp_bytes = '{8'hB0, 8'hA0, 8'hB1, 8'hA1, 8'hB2, 8'hA2};
        exp_own   = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        compare_out("rr");

        // Burst cap of 4: req1 sends 6 bytes with no last, req0 waits.
        for (int i = 0; i < 6; i++) q1.push_back({1'b0, 8'h10 + 8'(i)});
        run_cycle(1'b1);
        check_eq("cap_first_grant", grant_o, 2'b10);
        q0.push_back({1'b1, 8'h55});
        drain("cap");
        check_eq("cap_hold_grant", grant_o, 2'b10);
        check_eq("cap_hold_busy", busy_o, 1'b1);
        exp_bytes = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h55, 8'h14, 8'h15};
        exp_own   = '{2'b10, 2'b01, 2'b10};
        compare_out("cap");
        reset_i = 1'b0;
        #1 reset_i = 1'b1;
        prev_grant = 2'b00;

        // Backpressure: five stalled cycles with the buffer holding 0x23.
        for (int i = 0; i < 6; i++) q0.push_back({(i == 5), 8'h21 + 8'(i)});
        repeat (4) run_cycle(1'b1);
        check_eq("bp_pre", tx_data_o, 8'h23);
        for (int i = 0; i < 5; i++) begin
            run_cycle(1'b0);
            check_eq($sformatf("bp_txv%0d", i), tx_valid_o, 1'b1);
            check_eq($sformatf("bp_txd%0d", i), tx_data_o, 8'h23);
            check_eq($sformatf("bp_ready%0d", i), req_ready_o, 2'b00);
        end
        drain("bp");
        exp_bytes = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
        compare_out("bp");

        // Reset mid-burst while the third byte sits in the buffer.
        for (int i = 0; i < 6; i++) q0.push_back({1'b0, 8'h31 + 8'(i)});
        repeat (4) run_cycle(1'b1);
        check_eq("mid_third", tx_data_o, 8'h33);
        #2 reset_i = 1'b0;
        #1;
        check_eq("mid_txv", tx_valid_o, 1'b0);
        check_eq("mid_grant", grant_o, 2'b00);
        check_eq("mid_busy", busy_o, 1'b0);
        check_eq("mid_ready", req_ready_o, 2'b00);
        q0.delete();
        outq.delete();
        ownq.delete();
        req_valid_i = 2'b00;
        #1 reset_i = 1'b1;
        prev_grant = 2'b00;
        q0.push_back({1'b1, 8'h77});
        q1.push_back({1'b1, 8'h88});
        run_cycle(1'b1);
        check_eq("mid_rr_ptr", grant_o, 2'b01);
        drain("mid");
        exp_bytes = '{8'h77, 8'h88};
        compare_out("mid");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net against a hung simulation.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
